thread_regfile: RTL and testbench

Per-thread register file feeding the thread's ALU and LSU operand ports and capturing their results. One instance per thread, mirroring the ALU instance.
- Holds 16 registers of DATA_BITS.
- R0-R12 are general purpose.
- R13-R15 are read-only: %blockIdx, %blockDim, %threadIdx.
- Operand reads happen in the REQUEST core state; write-back happens in the UPDATE core state.

---
 rtl/thread_regfile.sv | 124 ++++++++++++
 tb/tb_thread_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only (%blockIdx, %blockDim, %threadIdx).
// Optional even-parity protection of R0-R12 with a sticky parity_err output when RF_PARITY_EN is defined.
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
`ifdef RF_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  typedef logic [DATA_BITS-1:0] data_t;

  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

  localparam logic [3:0] LAST_GP = 4'd12;
  localparam logic [3:0] R13     = 4'd13;
  localparam logic [3:0] R14     = 4'd14;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;

  localparam data_t BLOCK_DIM  = data_t'(THREADS_PER_BLOCK);
  localparam data_t THREAD_IDX = data_t'(THREAD_ID);

  data_t gp_regs [0:12];
  data_t block_idx;

  logic  wr_en;
  data_t wr_data;
  data_t rs_next;
  data_t rt_next;

  function automatic data_t read_reg(input logic [3:0] addr);
    if (addr <= LAST_GP)  return gp_regs[addr];
    else if (addr == R13) return block_idx;
    else if (addr == R14) return BLOCK_DIM;
    else                  return THREAD_IDX;
  endfunction

  // Writes aimed at R13-R15 never assert wr_en, so the read-only registers need no extra guard.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_en   = 1'b0;
    wr_data = '0;
    if (enable && core_state == UPDATE && decoded_reg_write_enable &&
        decoded_rd_address <= LAST_GP) begin
      unique case (decoded_reg_input_mux)
        MUX_ALU: begin wr_en = 1'b1; wr_data = alu_out;           end
        MUX_MEM: begin wr_en = 1'b1; wr_data = lsu_out;           end
        MUX_IMM: begin wr_en = 1'b1; wr_data = decoded_immediate; end
        default: begin wr_en = 1'b0; wr_data = '0;                end
      endcase
    end
  end

  always_comb begin
    rs_next = read_reg(decoded_rs_address);
    rt_next = read_reg(decoded_rt_address);
  end

  always_ff @(posedge clk) begin
    // NOTE: the register array is reset explicitly because R0 must read 0 right after reset.
    if (reset) begin
      for (int i = 0; i <= 12; i++) gp_regs[i] <= '0;
      block_idx <= '0;
      rs        <= '0;
      rt        <= '0;
    end else if (enable) begin
      // NOTE: non-blocking assignments keep R13 refresh and the operand read on the same edge race-free.
      block_idx <= data_t'(block_id);
      if (wr_en) gp_regs[decoded_rd_address] <= wr_data;
      if (core_state == REQUEST) begin
        rs <= rs_next;
        rt <= rt_next;
      end
    end
  end

`ifdef RF_PARITY_EN
  logic gp_par [0:12];
  logic rs_bad;
  logic rt_bad;

  // Only general-purpose sources are checked; R13-R15 carry no stored parity.
  always_comb begin
    rs_bad = 1'b0;
    rt_bad = 1'b0;
    if (decoded_rs_address <= LAST_GP)
      rs_bad = (^gp_regs[decoded_rs_address]) != gp_par[decoded_rs_address];
    if (decoded_rt_address <= LAST_GP)
      rt_bad = (^gp_regs[decoded_rt_address]) != gp_par[decoded_rt_address];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= 12; i++) gp_par[i] <= 1'b0;
      parity_err <= 1'b0;
    end else if (enable) begin
      if (wr_en) gp_par[decoded_rd_address] <= ^wr_data;
      if (core_state == REQUEST && (rs_bad || rt_bad)) parity_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_thread_regfile.sv
// Scoreboard bench for thread_regfile: driver pushes expected {rs, rt}; a monitor pops on every output update.
module tb_thread_regfile;

  localparam int DW = 8;
  localparam logic [2:0] IDLE    = 3'b000;
  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    block_id;
  logic [2:0]    core_state;
  logic [3:0]    rd_a, rs_a, rt_a;
  logic          we;
  logic [1:0]    mux;
  logic [DW-1:0] imm, alu_out, lsu_out;
  logic [DW-1:0] rs, rt;
`ifdef RF_PARITY_EN
  logic          parity_err;
`endif

  thread_regfile #(.THREADS_PER_BLOCK(4), .THREAD_ID(2), .DATA_BITS(DW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .block_id                 (block_id),
    .core_state               (core_state),
    .decoded_rd_address       (rd_a),
    .decoded_rs_address       (rs_a),
    .decoded_rt_address       (rt_a),
    .decoded_reg_write_enable (we),
    .decoded_reg_input_mux    (mux),
    .decoded_immediate        (imm),
    .alu_out                  (alu_out),
    .lsu_out                  (lsu_out),
`ifdef RF_PARITY_EN
    .parity_err               (parity_err),
`endif
    .rs                       (rs),
    .rt                       (rt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [7:0]    tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic obs_valid = 1'b0;

  // Operands update on a REQUEST edge or a reset edge; either one is an observation point.
  always @(posedge clk) obs_valid <= reset || (core_state == REQUEST);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (obs_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {rs, rt}, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("obs%0d_rs_rt", e.tag), {rs, rt}, {e.rs, e.rt});
        end
      end
    end
  end

  int tag_n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] ers, input logic [DW-1:0] ert);
    exp_q.push_back('{rs: ers, rt: ert, tag: 8'(tag_n)});
    tag_n++;
  endtask

  task automatic idle(input int n);
    core_state = IDLE;
    we         = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_request(input logic [3:0] a, input logic [3:0] b,
                            input logic [DW-1:0] ers, input logic [DW-1:0] ert);
    core_state = REQUEST;
    we         = 1'b0;
    rs_a       = a;
    rt_a       = b;
    push(ers, ert);
    tick();
    core_state = IDLE;
  endtask

  task automatic do_update(input logic [3:0] d, input logic w, input logic [1:0] m,
                           input logic [DW-1:0] alu, input logic [DW-1:0] lsu,
                           input logic [DW-1:0] im);
    core_state = UPDATE;
    rd_a       = d;
    we         = w;
    mux        = m;
    alu_out    = alu;
    lsu_out    = lsu;
    imm        = im;
    if (reset) push(8'h00, 8'h00);
    tick();
    core_state = IDLE;
    we         = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : driver
    reset = 1'b1; enable = 1'b1; block_id = 8'd0; core_state = IDLE;
    rd_a = '0; rs_a = '0; rt_a = '0; we = 1'b0; mux = 2'b11;
    imm = '0; alu_out = '0; lsu_out = '0;
    push(8'h00, 8'h00);
    tick();
    reset = 1'b0;

    // Reset contents and read-only constants.
    do_request(4'd14, 4'd15, 8'h04, 8'h02);
    do_request(4'd0,  4'd0,  8'h00, 8'h00);

    // Write-back from each mux source.
    do_update(4'd3, 1'b1, 2'b00, 8'h5A, 8'h00, 8'h00);
    do_request(4'd3, 4'd0, 8'h5A, 8'h00);
    do_update(4'd12, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFF);
    do_update(4'd0,  1'b1, 2'b01, 8'h00, 8'h11, 8'h00);
    do_request(4'd12, 4'd0, 8'hFF, 8'h11);

    // Dropped write to R14; R13 tracks block_id with one edge of lag.
    do_update(4'd14, 1'b1, 2'b10, 8'h00, 8'h00, 8'h77);
    do_request(4'd14, 4'd14, 8'h04, 8'h04);
    block_id = 8'd9;
    idle(2);
    do_request(4'd13, 4'd3, 8'h09, 8'h5A);
    block_id = 8'd3;
    do_request(4'd13, 4'd14, 8'h09, 8'h04);
    do_request(4'd13, 4'd13, 8'h03, 8'h03);

    // Write to R13 takes block_id, not the data.
    block_id = 8'd6;
    do_update(4'd13, 1'b1, 2'b10, 8'h00, 8'h00, 8'h55);
    do_request(4'd13, 4'd15, 8'h06, 8'h02);

    // mux=11 and we=0 leave the target untouched.
    do_update(4'd3, 1'b1, 2'b11, 8'hAA, 8'hAA, 8'hAA);
    do_update(4'd3, 1'b0, 2'b00, 8'hBB, 8'h00, 8'h00);
    do_request(4'd3, 4'd12, 8'h5A, 8'hFF);

    // enable=0 freezes registers, operands and R13.
    enable   = 1'b0;
    block_id = 8'd8;
    do_update(4'd3, 1'b1, 2'b00, 8'h33, 8'h00, 8'h00);
    do_request(4'd14, 4'd15, 8'h5A, 8'hFF);
    enable = 1'b1;
    do_request(4'd3, 4'd13, 8'h5A, 8'h06);
    do_request(4'd13, 4'd13, 8'h08, 8'h08);

    // Reset during an in-flight write-back.
    do_update(4'd5, 1'b1, 2'b00, 8'h21, 8'h00, 8'h00);
    do_request(4'd5, 4'd0, 8'h21, 8'h11);
    reset = 1'b1;
    do_update(4'd5, 1'b1, 2'b00, 8'h44, 8'h00, 8'h00);
    reset = 1'b0;
    do_request(4'd5,  4'd0,  8'h00, 8'h00);
    do_request(4'd14, 4'd15, 8'h04, 8'h02);
    do_request(4'd12, 4'd13, 8'h00, 8'h08);

`ifdef RF_PARITY_EN
    do_update(4'd5, 1'b1, 2'b00, 8'h21, 8'h00, 8'h00);
    check("parity_clean", {15'd0, parity_err}, 16'd0);
    dut.gp_regs[5] = dut.gp_regs[5] ^ 8'h01;
    do_request(4'd5, 4'd0, 8'h20, 8'h00);
    check("parity_set", {15'd0, parity_err}, 16'd1);
    idle(3);
    check("parity_sticky", {15'd0, parity_err}, 16'd1);
    reset = 1'b1;
    push(8'h00, 8'h00);
    tick();
    reset = 1'b0;
    check("parity_reset", {15'd0, parity_err}, 16'd0);
`endif

    idle(3);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
